// File: rtl/aoi_path_delay_sequencer.sv
// Characterisation sequencer for the AND-OR cell y = (a & b) | (c & d).
// Walks every 4-bit base vector and every single-pin toggle of it, times the
// cell's response in clock cycles and emits one record per toggle.
//
// Record stream: rec_valid_out is a one-cycle strobe with no back-pressure;
// every rec_* field is valid while rec_valid_out is high and holds its value
// until the next strobe. Exactly 64 strobes occur per completed sweep,
// ordered vec-major, pin-minor.
module aoi_path_delay_sequencer #(
  parameter int SETTLE_CYC = 4,
  parameter int TIMEOUT    = 15,
  parameter int CNT_W      = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic             y_obs_in,
  output logic             a_out,
  output logic             b_out,
  output logic             c_out,
  output logic             d_out,
  output logic             busy_out,
  output logic             done_out,
  output logic             rec_valid_out,
  output logic [3:0]       rec_vec_out,
  output logic [1:0]       rec_pin_out,
  output logic             rec_change_out,
  output logic [CNT_W-1:0] rec_delay_out,
  output logic             rec_timeout_out,
  output logic             rec_glitch_out,
  output logic             rec_base_err_out,
  output logic [CNT_W-1:0] max_delay_out,
  output logic [2:0]       dbg_state_out
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_APPLY   = 3'd1,
    S_SETTLE  = 3'd2,
    S_TOGGLE  = 3'd3,
    S_MEASURE = 3'd4,
    S_REPORT  = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  // Reference function of the cell under characterisation.
  function automatic logic f_ref(input logic [3:0] v);
    return (v[3] & v[2]) | (v[1] & v[0]);
  endfunction

  state_t           state, state_nxt;
  logic [3:0]       vec;
  logic [1:0]       pin;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       drive;
  logic             change_q;
  logic             base_err_q;
  logic             glitch_q;

  logic [3:0]       tog_vec;
  logic [CNT_W-1:0] cnt_inc;
  logic             settle_last;
  logic             match;
  logic             meas_timeout;
  logic             dev;
  logic             meas_end;
  logic             last_rec;

  // Pin 0 is cell pin a, which is the MSB of the vector.
  assign tog_vec      = vec ^ (4'b1000 >> pin);
  assign cnt_inc      = cnt + 1'b1;
  assign settle_last  = (cnt == CNT_W'(SETTLE_CYC - 1));
  assign match        = (y_obs_in == f_ref(tog_vec));
  assign meas_timeout = (cnt_inc == CNT_W'(TIMEOUT));
  assign dev          = (y_obs_in != f_ref(vec));
  assign meas_end     = change_q ? (match || meas_timeout) : settle_last;
  assign last_rec     = (vec == 4'hf) && (pin == 2'd3);

  assign a_out         = drive[3];
  assign b_out         = drive[2];
  assign c_out         = drive[1];
  assign d_out         = drive[0];
  assign dbg_state_out = state;

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start_in) state_nxt = S_APPLY;
      S_APPLY:   state_nxt = S_SETTLE;
      S_SETTLE:  if (settle_last) state_nxt = S_TOGGLE;
      S_TOGGLE:  state_nxt = S_MEASURE;
      S_MEASURE: if (meas_end) state_nxt = S_REPORT;
      S_REPORT:  state_nxt = last_rec ? S_DONE : S_APPLY;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Sweep datapath: cell drive, delay counter, record and summary registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      vec              <= '0;
      pin              <= '0;
      cnt              <= '0;
      drive            <= '0;
      change_q         <= 1'b0;
      base_err_q       <= 1'b0;
      glitch_q         <= 1'b0;
      busy_out         <= 1'b0;
      done_out         <= 1'b0;
      rec_valid_out    <= 1'b0;
      rec_vec_out      <= '0;
      rec_pin_out      <= '0;
      rec_change_out   <= 1'b0;
      rec_delay_out    <= '0;
      rec_timeout_out  <= 1'b0;
      rec_glitch_out   <= 1'b0;
      rec_base_err_out <= 1'b0;
      max_delay_out    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_in) begin
            vec           <= '0;
            pin           <= '0;
            max_delay_out <= '0;
            busy_out      <= 1'b1;
          end
        end
        S_APPLY: begin
          drive <= vec;
          cnt   <= '0;
        end
        S_SETTLE: begin
          if (settle_last) base_err_q <= dev;
          else             cnt        <= cnt_inc;
        end
        S_TOGGLE: begin
          drive    <= tog_vec;
          change_q <= (f_ref(vec) != f_ref(tog_vec));
          cnt      <= '0;
          glitch_q <= 1'b0;
        end
        S_MEASURE: begin
          // Counter includes the current cycle and never passes TIMEOUT.
          if (cnt != CNT_W'(TIMEOUT)) cnt <= cnt_inc;
          glitch_q <= glitch_q | dev;
          if (meas_end) begin
            rec_valid_out    <= 1'b1;
            rec_vec_out      <= vec;
            rec_pin_out      <= pin;
            rec_change_out   <= change_q;
            rec_base_err_out <= base_err_q;
            if (change_q) begin
              // A match on the last allowed cycle still counts as a response.
              rec_timeout_out <= !match;
              rec_delay_out   <= match ? cnt_inc : CNT_W'(TIMEOUT);
              rec_glitch_out  <= 1'b0;
            end else begin
              rec_timeout_out <= 1'b0;
              rec_delay_out   <= '0;
              rec_glitch_out  <= glitch_q | dev;
            end
          end
        end
        S_REPORT: begin
          rec_valid_out <= 1'b0;
          if (rec_change_out && !rec_timeout_out && (rec_delay_out > max_delay_out))
            max_delay_out <= rec_delay_out;
          pin <= pin + 1'b1;
          if (pin == 2'd3) vec <= vec + 1'b1;
          if (last_rec) done_out <= 1'b1;
        end
        S_DONE: begin
          done_out <= 1'b0;
          drive    <= '0;
          busy_out <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aoi_path_delay_sequencer.sv
// Bench for aoi_path_delay_sequencer: a behavioural cell model closes the loop
// from a..d back to y_obs_in; expected records are queued per sweep and a
// monitor compares each strobed record in order.
module tb_aoi_path_delay_sequencer;

  localparam int CNT_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_in;
  logic             start_in;
  logic             y_obs_in;
  logic             a_out, b_out, c_out, d_out;
  logic             busy_out, done_out, rec_valid_out;
  logic [3:0]       rec_vec_out;
  logic [1:0]       rec_pin_out;
  logic             rec_change_out;
  logic [CNT_W-1:0] rec_delay_out;
  logic             rec_timeout_out, rec_glitch_out, rec_base_err_out;
  logic [CNT_W-1:0] max_delay_out;
  logic [2:0]       dbg_state_out;

  aoi_path_delay_sequencer #(.SETTLE_CYC(4), .TIMEOUT(15), .CNT_W(CNT_W)) dut (
    .clk_in           (clk),
    .rst_in           (rst_in),
    .start_in         (start_in),
    .y_obs_in         (y_obs_in),
    .a_out            (a_out),
    .b_out            (b_out),
    .c_out            (c_out),
    .d_out            (d_out),
    .busy_out         (busy_out),
    .done_out         (done_out),
    .rec_valid_out    (rec_valid_out),
    .rec_vec_out      (rec_vec_out),
    .rec_pin_out      (rec_pin_out),
    .rec_change_out   (rec_change_out),
    .rec_delay_out    (rec_delay_out),
    .rec_timeout_out  (rec_timeout_out),
    .rec_glitch_out   (rec_glitch_out),
    .rec_base_err_out (rec_base_err_out),
    .max_delay_out    (max_delay_out),
    .dbg_state_out    (dbg_state_out)
  );

  // ---------------- cell model ----------------
  // mode 0: ideal, 1: 3-cycle latency, 2: stuck at 0, 3: ideal plus injected pulse
  int   cell_mode = 0;
  logic inject    = 1'b0;
  logic d1 = 1'b0, d2 = 1'b0, d3 = 1'b0;

  function automatic logic fr(input logic [3:0] v);
    return (v[3] & v[2]) | (v[1] & v[0]);
  endfunction

  always @(posedge clk) begin
    d1 <= fr({a_out, b_out, c_out, d_out});
    d2 <= d1;
    d3 <= d2;
  end

  assign y_obs_in = (cell_mode == 1) ? d3 :
                    (cell_mode == 2) ? 1'b0 :
                    (fr({a_out, b_out, c_out, d_out}) ^ inject);

  // ---------------- scoreboard ----------------
  int          n_checks  = 0;
  int          n_fail    = 0;
  int          rec_seen  = 0;
  int          done_seen = 0;
  logic [13:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected record {vec, pin, change, delay, timeout, glitch, base_err}.
  function automatic logic [13:0] exp_rec(input int mode, input int v, input int p);
    logic [3:0] vb, tv, dl;
    logic [1:0] pb;
    logic       ch, to, gl, be;
    vb = v[3:0];
    pb = p[1:0];
    tv = vb ^ (4'b1000 >> pb);
    ch = (fr(vb) != fr(tv));
    dl = 4'd0; to = 1'b0; gl = 1'b0; be = 1'b0;
    case (mode)
      1: dl = ch ? 4'd4 : 4'd0;
      2: begin
        be = fr(vb);
        if (ch) begin
          if (fr(tv)) begin to = 1'b1; dl = 4'd15; end
          else dl = 4'd1;
        end else begin
          gl = fr(vb);
        end
      end
      default: begin
        dl = ch ? 4'd1 : 4'd0;
        if (mode == 3 && v == 0 && p == 1) gl = 1'b1;
      end
    endcase
    return {vb, pb, ch, dl, to, gl, be};
  endfunction

  // Monitor: compare every strobed record against the head of the queue.
  always @(negedge clk) begin
    if (!rst_in) begin
      if (rec_valid_out) begin
        check($sformatf("rec_%0d_queued", rec_seen), (exp_q.size() > 0), 1);
        if (exp_q.size() > 0)
          check($sformatf("rec_%0d", rec_seen),
                {rec_vec_out, rec_pin_out, rec_change_out, rec_delay_out,
                 rec_timeout_out, rec_glitch_out, rec_base_err_out},
                exp_q.pop_front());
        rec_seen++;
      end
      if (done_out) done_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_sweep(input int mode);
    cell_mode = mode;
    for (int v = 0; v < 16; v++)
      for (int p = 0; p < 4; p++)
        exp_q.push_back(exp_rec(mode, v, p));
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    check("busy_after_start", busy_out, 1);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done_out && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("done_within_budget", done_out, 1);
  endtask

  task automatic wait_state(input logic [2:0] st, input string name);
    int k;
    k = 0;
    while (dbg_state_out != st && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(name, dbg_state_out, st);
  endtask

  task automatic wait_recs(input int target, input string name);
    int k;
    k = 0;
    while (rec_seen < target && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(name, (rec_seen >= target), 1);
  endtask

  // Called on the done_out cycle.
  task automatic post_done_checks(input logic [CNT_W-1:0] emax, input int d0);
    check("records_left_at_done", exp_q.size(), 0);
    check("max_delay", max_delay_out, emax);
    @(negedge clk);
    check("done_one_cycle", done_out, 0);
    check("busy_drop", busy_out, 0);
    check("pins_idle", {a_out, b_out, c_out, d_out}, 0);
    check("state_idle_after_done", dbg_state_out, 0);
    check("done_pulses", done_seen - d0, 1);
  endtask

  task automatic run_sweep(input int mode, input logic [CNT_W-1:0] emax);
    int d0;
    push_sweep(mode);
    d0 = done_seen;
    pulse_start();
    wait_done();
    post_done_checks(emax, d0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_abcd"}, {a_out, b_out, c_out, d_out}, 0);
    check({tag, "_busy"}, busy_out, 0);
    check({tag, "_done"}, done_out, 0);
    check({tag, "_rec_valid"}, rec_valid_out, 0);
    check({tag, "_rec_fields"},
          {rec_vec_out, rec_pin_out, rec_change_out, rec_delay_out,
           rec_timeout_out, rec_glitch_out, rec_base_err_out}, 0);
    check({tag, "_max_delay"}, max_delay_out, 0);
    check({tag, "_state"}, dbg_state_out, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base, d0;
    rst_in   = 1'b1;
    start_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_in = 1'b0;

    // Ideal cell: change delay 1, max 1.
    run_sweep(0, 4'd1);
    // 3-cycle latency cell: change delay 4.
    run_sweep(1, 4'd4);
    // Output stuck at 0: timeouts, base errors, glitches on f(base)=1.
    run_sweep(2, 4'd1);

    // Single-cycle pulse during MEASURE of vec=0000, pin=1.
    push_sweep(3);
    d0   = done_seen;
    base = rec_seen;
    pulse_start();
    wait_recs(base + 1, "pulse_wait_rec0");
    wait_state(3'd4, "pulse_wait_measure");
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    wait_done();
    post_done_checks(4'd1, d0);

    // Reset during MEASURE of record 20 aborts the sweep.
    push_sweep(0);
    d0   = done_seen;
    base = rec_seen;
    pulse_start();
    wait_recs(base + 20, "abort_wait_rec20");
    wait_state(3'd4, "abort_wait_measure");
    rst_in = 1'b1;
    @(negedge clk);
    check_all_zero("abort");
    check("abort_rec_count", rec_seen - base, 20);
    rst_in = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("abort_no_done", done_seen - d0, 0);
    check("abort_stays_idle", dbg_state_out, 0);
    // Restart must begin again at vec=0, pin=0.
    run_sweep(0, 4'd1);

    // start_in held high through a sweep; back-to-back restart after done.
    push_sweep(0);
    d0 = done_seen;
    @(negedge clk);
    start_in = 1'b1;
    wait_done();
    check("held_records_left", exp_q.size(), 0);
    push_sweep(0);
    @(negedge clk);
    check("held_idle_busy", busy_out, 0);
    check("held_idle_state", dbg_state_out, 0);
    check("held_done_pulses", done_seen - d0, 1);
    @(negedge clk);
    check("held_restart_busy", busy_out, 1);
    start_in = 1'b0;
    d0 = done_seen;
    wait_done();
    post_done_checks(4'd1, d0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
